// File: rtl/bcd_seg_scan.sv
// -----------------------------------------------------------------------------
// bcd_seg_scan
//   Time-multiplexed driver for a three-digit seven-segment display. A packed
//   three-digit BCD value is loaded into a pending buffer. The buffer is copied
//   into the displayed value only at a frame boundary, so a frame never shows a
//   mix of old and new digits. The scan walks units -> tens -> hundreds, holding
//   each digit for CLK_DIV clock cycles. Optional leading-zero blanking applies.
//
// Parameters
//   CLK_DIV    clk cycles per digit slot (2 .. 2**20)
//   ACTIVE_LOW 1 = seg/an driven active-low (common anode), 0 = active-high
//
// Ports
//   clk      in   rising-edge system clock
//   rst_n    in   asynchronous active-low reset
//   bcd      in   [11:8] hundreds, [7:4] tens, [3:0] units
//   load     in   one-cycle strobe; bcd is sampled on the same edge
//   blank_lz in   1 = blank leading zeros (sampled every cycle)
//   seg      out  segments {g,f,e,d,c,b,a}, registered
//   an       out  digit enables [2] hundreds, [1] tens, [0] units, registered
//   frame    out  one-cycle pulse after each completed scan frame, registered
// -----------------------------------------------------------------------------
module bcd_seg_scan #(
  parameter int CLK_DIV    = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame
);

  localparam int             DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  // Output polarity mask: XOR with the active-high value gives the pin level.
  localparam logic [6:0]     SEG_POL  = {7{ACTIVE_LOW}};
  localparam logic [2:0]     AN_POL   = {3{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    DIG0 = 2'd0,  // units
    DIG1 = 2'd1,  // tens
    DIG2 = 2'd2   // hundreds
  } state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          boundary;
  state_t        state;
  state_t        state_nxt;

  logic [11:0]   pend;
  logic          pend_v;
  logic [11:0]   shown;

  logic [3:0]    nib;
  logic          blanked;
  logic [6:0]    seg_raw;
  logic [2:0]    an_raw;

  // ---------------------------------------------------------------------------
  // Slot divider
  // ---------------------------------------------------------------------------
  assign tick     = (div_cnt == DIV_LAST);
  assign boundary = tick && (state == DIG2);

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIG0;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the default assignment before the case keeps this purely
  // combinational; any path that skipped state_nxt would infer a latch.
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        DIG0:    state_nxt = DIG1;
        DIG1:    state_nxt = DIG2;
        DIG2:    state_nxt = DIG0;
        default: state_nxt = DIG0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffer: pend collects loads; shown changes only at a frame boundary.
  // A load that coincides with the boundary goes straight to shown and clears
  // pend_v, so an older pending value can never resurface.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      pend_v <= 1'b0;
      shown  <= '0;
    end else begin
      if (load) begin
        pend <= bcd;
      end
      if (boundary) begin
        pend_v <= 1'b0;
        if (load) begin
          shown <= bcd;
        end else if (pend_v) begin
          shown <= pend;
        end
      end else if (load) begin
        pend_v <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select, leading-zero blanking and segment decode (active-high).
  // Non-BCD nibbles (10..15) count as non-zero, so they never blank.
  // ---------------------------------------------------------------------------
  always_comb begin
    nib     = shown[3:0];
    blanked = 1'b0;
    an_raw  = 3'b001;
    case (state)
      DIG1: begin
        nib     = shown[7:4];
        blanked = blank_lz && (shown[11:4] == 8'h00);
        an_raw  = 3'b010;
      end
      DIG2: begin
        nib     = shown[11:8];
        blanked = blank_lz && (shown[11:8] == 4'h0);
        an_raw  = 3'b100;
      end
      default: begin
        nib     = shown[3:0];
        blanked = 1'b0;
        an_raw  = 3'b001;
      end
    endcase

    case (nib)
      4'd0:    seg_raw = 7'b0111111;
      4'd1:    seg_raw = 7'b0000110;
      4'd2:    seg_raw = 7'b1011011;
      4'd3:    seg_raw = 7'b1001111;
      4'd4:    seg_raw = 7'b1100110;
      4'd5:    seg_raw = 7'b1101101;
      4'd6:    seg_raw = 7'b1111101;
      4'd7:    seg_raw = 7'b0000111;
      4'd8:    seg_raw = 7'b1111111;
      4'd9:    seg_raw = 7'b1101111;
      default: seg_raw = 7'b1000000;  // dash for 10..15
    endcase

    if (blanked) begin
      seg_raw = 7'b0000000;
      an_raw  = 3'b000;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: one cycle behind the FSM state, polarity applied here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg   <= SEG_POL;
      an    <= AN_POL;
      frame <= 1'b0;
    end else begin
      seg   <= seg_raw ^ SEG_POL;
      an    <= an_raw ^ AN_POL;
      frame <= boundary;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_seg_scan
//   Directed bench for bcd_seg_scan with CLK_DIV=4, ACTIVE_LOW=0. One frame is
//   12 cycles. The bench counts clock edges after reset release. Digit k is
//   visible on edges 12n+4k+1 .. 12n+4k+4, and frame is high after every 12th
//   edge. Expected segment patterns come from a hand-written digit table.
// -----------------------------------------------------------------------------
module tb_bcd_seg_scan;

  logic        clk;
  logic        rst_n;
  logic [11:0] bcd;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        frame;

  int n_checks = 0;
  int n_fails  = 0;

  bcd_seg_scan #(
    .CLK_DIV    (4),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bcd      (bcd),
    .load     (load),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Active-high {g..a} pattern for one nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // One clock: sample 1 time unit after the edge; any load strobe ends here.
  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Assert reset away from the edge and check the asynchronous effect, then
  // release 1 time unit after the next edge (cycle count restarts at 0).
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check({tag, " seg"},   32'(seg),   32'h00);
    check({tag, " an"},    32'(an),    32'h0);
    check({tag, " frame"}, 32'(frame), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Run one 12-cycle frame expecting value `val` on the display. Optional loads
  // are applied before slot ld1/ld2 (slot 11 coincides with the boundary edge).
  task automatic run_frame(input string tag, input logic [11:0] val, input logic blank,
                           input int ld1, input logic [11:0] v1,
                           input int ld2, input logic [11:0] v2);
    logic [3:0] nibs [3];
    logic       blk;
    int         d;
    nibs[0] = val[3:0];
    nibs[1] = val[7:4];
    nibs[2] = val[11:8];
    for (int i = 0; i < 12; i++) begin
      if (i == ld1) begin
        load = 1'b1;
        bcd  = v1;
      end
      if (i == ld2) begin
        load = 1'b1;
        bcd  = v2;
      end
      step();
      d   = i / 4;
      blk = blank && ((d == 2 && val[11:8] == 4'h0) || (d == 1 && val[11:4] == 8'h00));
      check($sformatf("%s c%0d an", tag, i + 1), 32'(an),
            blk ? 32'h0 : 32'(3'b001 << d));
      check($sformatf("%s c%0d seg", tag, i + 1), 32'(seg),
            blk ? 32'h0 : 32'(seg7(nibs[d])));
      check($sformatf("%s c%0d frame", tag, i + 1), 32'(frame),
            32'(i == 11));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    bcd      = 12'h000;
    load     = 1'b0;
    blank_lz = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then a load in the release cycle; first frame shows 000.
    do_reset("rst1");
    load = 1'b1;
    bcd  = 12'h123;
    run_frame("f1_zero", 12'h000, 1'b0, -1, 12'h0, -1, 12'h0);
    run_frame("f2_123",  12'h123, 1'b0, -1, 12'h0, -1, 12'h0);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    run_frame("f3_123b", 12'h123, 1'b1, 0, 12'h007, -1, 12'h0);
    run_frame("f4_007b", 12'h007, 1'b1, 5, 12'h040, -1, 12'h0);
    run_frame("f5_040b", 12'h040, 1'b1, -1, 12'h0, -1, 12'h0);

    // Two loads mid-frame: nothing changes until the boundary, the last wins.
    run_frame("f6_hold", 12'h040, 1'b1, 3, 12'h255, 8, 12'h099);
    // Older pend (222), then a load on the exact boundary cycle (111).
    run_frame("f7_099b", 12'h099, 1'b1, 5, 12'h222, 11, 12'h111);
    run_frame("f8_111",  12'h111, 1'b1, -1, 12'h0, -1, 12'h0);
    run_frame("f9_111",  12'h111, 1'b1, 2, 12'hA5F, -1, 12'h0);

    // Non-BCD nibbles show a dash and are never blanked.
    run_frame("f10_a5fb", 12'hA5F, 1'b1, -1, 12'h0, -1, 12'h0);
    blank_lz = 1'b0;
    run_frame("f11_a5f",  12'hA5F, 1'b0, -1, 12'h0, -1, 12'h0);

    // Reset in DIG1 with a pending value: the pending value must be lost.
    load = 1'b1;
    bcd  = 12'h777;
    repeat (6) step();
    do_reset("rst2");
    run_frame("r1_zero", 12'h000, 1'b0, -1, 12'h0, -1, 12'h0);
    run_frame("r2_zero", 12'h000, 1'b0, -1, 12'h0, -1, 12'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 Parameter: CLK_DIV, default 50000, clk cycles per digit slot (legal range 2..2^20).
REQ-002 Parameter: ACTIVE_LOW, default 1, 1 = seg/an active-low (common anode), 0 = active-high.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  rising-edge system clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: bcd  input  12  three packed BCD digits from the binary-to-BCD stage ([11:8] hundreds, [7:4] tens, [3:0] units).
REQ-007 Port: load  input  1  one-cycle strobe; samples bcd on the same rising edge.
REQ-008 Port: blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-009 Port: seg  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-010 Port: an  output  3  digit enables ([2] hundreds, [1] tens, [0] units), registered.
REQ-011 Port: frame  output  1  one-cycle pulse at each completed scan frame, registered.

Function
REQ-012 Divider div_cnt SHALL count 0..CLK_DIV-1 and wrap to 0; tick = (div_cnt == CLK_DIV-1).
REQ-013 Scan FSM states: DIG0 -> DIG1 -> DIG2 -> DIG0, advancing only on tick; no other transitions.
REQ-014 Frame boundary = tick while in DIG2; frame SHALL be 1 in the cycle after the boundary edge and 0 otherwise.
REQ-015 A load SHALL write bcd into pend and set pend_v; a later load before the boundary SHALL overwrite pend (last value wins).
REQ-016 At a boundary with pend_v=1, shown <= pend and pend_v <= 0; with pend_v=0, shown is unchanged.
REQ-017 If load and a boundary coincide, shown <= bcd directly and pend_v SHALL end at 0 (new data wins over any older pend).
REQ-018 Displayed value SHALL never change mid-frame (no tearing).
REQ-019 Decode per digit, active-high {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; nibbles 10..15 SHALL show dash 1000000.
REQ-020 Blanking (blank_lz=1): hundreds blanked if shown[11:8]==0; tens blanked if shown[11:8]==0 and shown[7:4]==0; units never blanked. Non-BCD nibbles are not zero and are never blanked.
REQ-021 A blanked digit SHALL drive all segments off and keep its an inactive.
REQ-022 In state DIGk, exactly an[k] is active (unless blanked); seg/an SHALL reflect the FSM state with exactly one cycle of latency.
REQ-023 ACTIVE_LOW=1 SHALL invert both seg and an at the output registers.
REQ-024 blank_lz is sampled every cycle (not frame-aligned).

Reset
REQ-025 On rst_n=0, asynchronously: div_cnt=0, state=DIG0, shown=0, pend=0, pend_v=0, frame=0, all segments and digits inactive (ACTIVE_LOW=1: seg=1111111, an=111).
REQ-026 First clock after reset release SHALL drive units digit "0" (an[0] active, seg=0111111 active-high).
REQ-027 Reset asserted mid-frame SHALL discard pend and shown; a load in the release cycle SHALL be honoured normally.

Verification (CLK_DIV=4, ACTIVE_LOW=0)
REQ-028 Reset, load bcd=0x123, run 2 frames -> frame 2 shows an=001/seg 1001111 (3), 010/1011011 (2), 100/0000110 (1), each for 4 cycles; frame pulses every 12 cycles.
REQ-029 blank_lz=1, bcd=0x007 -> hundreds and tens dark (an=000, seg=0), units shows 0000111; bcd=0x040 -> hundreds dark, tens 1100110, units 0111111.
REQ-030 Load 0x255 mid-frame then 0x099 before boundary -> display unchanged until boundary, then 0x099; 0x255 never displayed.
REQ-031 Load 0x111 in the exact boundary cycle -> next frame shows 0x111, pend_v=0 afterwards.
REQ-032 bcd=0xA5F -> hundreds and units show dash 1000000, tens shows 5 (1101101), also with blank_lz=1.
REQ-033 Assert rst_n low during DIG1 with pend_v=1 -> outputs immediately inactive; after release display 0 from DIG0, pending value lost.
